// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types and constants for the ALU slice sequencer.
//   seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   NIBBLE_W    : width of one ParallelALU slice
//   *_S / *_M   : function-select / mode pairs the central unit drives
//                 through req_s / req_m for common operations
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NIBBLE_W = 4;

  // Arithmetic operations (M=0, carry chained through the slices)
  localparam logic [3:0] ADD_S = 4'b1001;
  localparam logic       ADD_M = 1'b0;
  localparam logic [3:0] SUB_S = 4'b0110;
  localparam logic       SUB_M = 1'b0;

  // Logic operations (M=1, carry still chained but not meaningful)
  localparam logic [3:0] AND_S = 4'b1011;
  localparam logic       AND_M = 1'b1;
  localparam logic [3:0] OR_S  = 4'b1110;
  localparam logic       OR_M  = 1'b1;
  localparam logic [3:0] XOR_S = 4'b0110;
  localparam logic       XOR_M = 1'b1;
  localparam logic [3:0] NOT_S = 4'b0000;
  localparam logic       NOT_M = 1'b1;

endpackage

// File: rtl/alu_seq_opcounter.sv
// alu_seq_opcounter
// Saturating 16-bit count of completed sequencer operations. Only
// instantiated when ALU_SEQ_OPCOUNT_EN is defined.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   inc   : one completed operation this cycle
//   count : current count, sticks at 16'hFFFF
module alu_seq_opcounter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  // Count handshakes, holding at all-ones instead of wrapping back to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
// Drives a single 4-bit ParallelALU slice one nibble per cycle (LSB
// first), chaining each nibble's Pout into the next nibble's Pin, then
// returns the assembled WORD_W-bit result on a valid/ready channel.
//   clk, rst_n          : clock and synchronous active-low reset
//   req_valid/req_ready : request handshake; req_a, req_b, req_s, req_m,
//                         req_cin are sampled only at the accept edge
//   resp_valid/resp_ready : response handshake; resp_r, resp_cout,
//                         resp_zero held stable while resp_valid is high
//   alu_a, alu_b, alu_s, alu_m, alu_pin : drive to the ALU slice
//   alu_r, alu_pout     : combinational result back from the ALU slice
//   op_count            : completed-operation count, present only when
//                         ALU_SEQ_OPCOUNT_EN is defined
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic [3:0]        req_s,
  input  logic              req_m,
  input  logic              req_cin,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_r,
  output logic              resp_cout,
  output logic              resp_zero,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [3:0]        alu_s,
  output logic              alu_m,
  output logic              alu_pin,
  input  logic [3:0]        alu_r,
  input  logic              alu_pout
`ifdef ALU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int NIBBLES = WORD_W / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WORD_W < NIBBLE_W) || ((WORD_W % NIBBLE_W) != 0)) begin : g_bad_width
      $error("alu_slice_sequencer: WORD_W must be a positive multiple of 4");
    end
  endgenerate

  seq_state_t        state;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] result_q;
  logic [3:0]        s_q;
  logic              m_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx;

  // Sequencer FSM. In IDLE the operands are captured; each RUN edge
  // stores one result nibble and moves the slice carry into carry_q so it
  // feeds the next nibble. After the MSB nibble carry_q holds the final
  // carry-out, which doubles as resp_cout in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            s_q     <= req_s;
            m_q     <= req_m;
            carry_q <= req_cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result_q[NIBBLE_W*idx +: NIBBLE_W] <= alu_r;
          carry_q <= alu_pout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slice drive: operand nibbles only while running, so the ALU sees
  // zeros between operations; function select and carry always reflect
  // the latched registers.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state == RUN) begin
      alu_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
      alu_b = b_q[NIBBLE_W*idx +: NIBBLE_W];
    end
  end

  assign alu_s   = s_q;
  assign alu_m   = m_q;
  assign alu_pin = carry_q;

  // Handshake flags come straight from the state register; req_ready is
  // also masked by reset so nothing looks acceptable while held in reset.
  assign req_ready  = rst_n && (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_r     = result_q;
  assign resp_cout  = carry_q;
  assign resp_zero  = (result_q == '0);

`ifdef ALU_SEQ_OPCOUNT_EN
  alu_seq_opcounter u_opcounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_valid && resp_ready),
    .count (op_count)
  );
`endif

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Control-side initiator for the 4-bit parallel ALU slice: accepts a WORD_W-bit operation request, drives the slice one nibble per cycle from LSB to MSB, and chains carry from each nibble's Pout into the next nibble's Pin.
- Assembles the result and returns it over a valid/ready response channel with carry-out and zero flags.
- Sits between the central unit's instruction/operand logic and a single ParallelALU instance; the integration wrapper makes that connection.

Parameters:
- WORD_W, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WORD_W/4, derived slice count; not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  sequencer can accept a request
- req_a  in  WORD_W  operand A
- req_b  in  WORD_W  operand B
- req_s  in  4  ALU function select, passed unchanged to alu_s
- req_m  in  1  ALU mode, passed unchanged to alu_m
- req_cin  in  1  carry into nibble 0
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_r  out  WORD_W  assembled result
- resp_cout  out  1  Pout of the MSB nibble
- resp_zero  out  1  resp_r == 0
- alu_a  out  4  current A nibble
- alu_b  out  4  current B nibble
- alu_s  out  4  latched req_s
- alu_m  out  1  latched req_m
- alu_pin  out  1  carry into current nibble
- alu_r  in  4  ALU result nibble, combinational from alu_* outputs
- alu_pout  in  1  ALU carry out

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset value is IDLE.
- Reset values:
  - Registers: operand, result and carry registers all 0; nibble index 0.
  - Outputs: req_ready=0 while rst_n low; resp_valid=0; resp_r=0; resp_cout=0; alu_* outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch a, b, s, m; load carry reg with req_cin; set idx=0; go to RUN.
- RUN:
  - alu_a=a[4*idx+:4], alu_b=b[4*idx+:4], alu_pin=carry reg.
  - Each edge: result[4*idx+:4] <= alu_r; carry <= alu_pout; idx++.
  - On the edge capturing idx==NIBBLES-1, go to DONE.
- DONE:
  - resp_valid=1; resp_r, resp_cout and resp_zero are stable registered values.
  - On resp_ready: go to IDLE.
  - req_ready=0; no request is accepted in the same cycle as the response handshake.
- Latency: resp_valid rises exactly NIBBLES cycles after the accepting edge. Throughput is one operation per NIBBLES+2 cycles.
- Outside RUN: alu_a=alu_b=0, alu_s/alu_m hold latched values, alu_pin=carry reg.
- Carry polarity: chained as-is with no inversion. In logic mode (M=1) carry is still chained and reported; its meaning is the ALU's.
- resp_zero is computed from the registered result.
- Reset mid-operation: the next state is IDLE, all registers clear, and no response is produced for the aborted request.
- req_* inputs are sampled only at the accept edge; later changes are ignored.

Optional Feature:
- Macro: ALU_SEQ_OPCOUNT_EN.
- Defined:
  - Adds output op_count [15:0].
  - Increments on each resp_valid&&resp_ready handshake; saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - State enum (IDLE, RUN, DONE).
  - NIBBLE_W=4.
  - Named S/M constants used by the central unit (e.g. ADD_S, ADD_M).
- Optional sub-module alu_seq_opcounter, the saturating 16-bit counter, instantiated under the macro.
- The sequencer does not instantiate the ALU.

Test Plan:
- Bench stub: alu_r/alu_pout = 4-bit sum and carry of alu_a+alu_b+alu_pin.
- Reset: rst_n low 2 cycles with req_valid=1 -> req_ready=0, resp_valid=0, no accept; after release req_ready=1.
- WORD_W=16, A=16'h00FF, B=16'h0001, cin=0 -> alu_pin sequence 0,1,1,0; resp_valid exactly 4 cycles after accept; resp_r=16'h0100, cout=0, zero=0.
- A=16'hFFFF, B=16'h0001, cin=0 -> resp_r=16'h0000, cout=1, zero=1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid while req_valid=1 with new operands -> resp_r stable and req_ready=0 throughout. After the handshake, the second request is accepted and completes with its own correct result.
- Reset pulsed after 2 RUN cycles -> IDLE next cycle, resp_valid never rises for the aborted op; a following A=16'h1234, B=16'h1111 op returns 16'h2345.
- With ALU_SEQ_OPCOUNT_EN: 3 completed ops -> op_count=3. Force 65535 ops or preload in sim -> op_count stays 16'hFFFF.
